// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage pipeline.
//   Runs loads and stores over a req/ack data-memory bus. Store data is steered
//   onto byte lanes; load data is extracted and sign- or zero-extended.
//   While an access is outstanding, it stalls the upstream stages.
//   Results, exceptions and bubbles are written to the registered MEM/WB slot.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   mem_*                   EX/MEM register fields (address/result, rd, controls)
//   dmem_req/we/addr/wdata/be  registered data-memory request
//   dmem_rdata, dmem_ack    memory response; ack completes the request that cycle
//   stall                   combinational; freezes PC, IF/ID, ID/EX, EX/MEM
//   wb_*, exc_*             registered MEM/WB outputs and 1-cycle exception pulses
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_alu_result,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_load_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        exc_misaligned,
    output logic        exc_bus_timeout
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [4:0]       rd_q, rd_d;
    logic             rw_q, rw_d;
    logic [31:0]      wb_result_q, wb_result_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_rw_q, wb_rw_d;
    logic             exc_mis_q, exc_mis_d;
    logic             exc_to_q, exc_to_d;

    logic        access_c, misaligned_c, timeout_c, stall_c;
    logic [31:0] st_wdata_c, ld_data_c;
    logic [3:0]  st_be_c;
    logic [15:0] ld_half_c;

    // If both read and write are set, the access is treated as a load.
    assign access_c     = mem_mem_read | mem_mem_write;
    assign misaligned_c = access_c &
                          ((mem_size[1] & (mem_alu_result[1:0] != 2'b00)) |
                           ((mem_size == 2'b01) & mem_alu_result[0]));
    // An ack takes priority over the timeout because it is checked first in REQ.
    assign timeout_c    = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Store lane replication and byte enables
    always_comb begin
        st_wdata_c = mem_store_data;
        st_be_c    = 4'b1111;
        case (mem_size)
            2'b00: begin
                st_wdata_c = {4{mem_store_data[7:0]}};
                st_be_c    = 4'b0001 << mem_alu_result[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{mem_store_data[15:0]}};
                st_be_c    = mem_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        ld_half_c = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_data_c = dmem_rdata;
        case (size_q)
            2'b00: ld_data_c = {{24{~uns_q & dmem_rdata[{off_q, 3'b000} + 5'd7]}},
                                dmem_rdata[{off_q, 3'b000} +: 8]};
            2'b01: ld_data_c = {{16{~uns_q & ld_half_c[15]}}, ld_half_c};
            default: ;
        endcase
    end

    // Next-state, latched request fields and MEM/WB slot
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = 1'b0;
        exc_mis_d   = 1'b0;
        exc_to_d    = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (misaligned_c) begin
                    exc_mis_d = 1'b1;
                    wb_rd_d   = mem_rd;
                end else if (access_c) begin
                    stall_c = 1'b1;
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = ~mem_mem_read;
                    waddr_d = mem_alu_result[31:2];
                    off_d   = mem_alu_result[1:0];
                    size_d  = mem_size;
                    uns_d   = mem_load_unsigned;
                    wdata_d = st_wdata_c;
                    be_d    = st_be_c;
                    rd_d    = mem_rd;
                    rw_d    = mem_reg_write;
                end else begin
                    wb_result_d = mem_alu_result;
                    wb_rd_d     = mem_rd;
                    wb_rw_d     = mem_reg_write;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wb_rd_d = rd_q;
                    if (!we_q) begin
                        wb_result_d = ld_data_c;
                        wb_rw_d     = rw_q;
                    end
                end else if (timeout_c) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    exc_to_d = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            exc_mis_q   <= 1'b0;
            exc_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            exc_mis_q   <= exc_mis_d;
            exc_to_q    <= exc_to_d;
        end
    end

    // Stall releases immediately while reset is asserted.
    assign stall           = stall_c & ~reset;
    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = {waddr_q, 2'b00};
    assign dmem_wdata      = wdata_q;
    assign dmem_be         = be_q;
    assign wb_result       = wb_result_q;
    assign wb_rd           = wb_rd_q;
    assign wb_reg_write    = wb_rw_q;
    assign exc_misaligned  = exc_mis_q;
    assign exc_bus_timeout = exc_to_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage (TIMEOUT_CYCLES = 4): a vector table driven through
// an ack-scheduling driver, with a scoreboard queue for MEM/WB results, plus
// hand-written reset/pulse/idle-ack sequences.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_alu_result, mem_store_data, dmem_rdata;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_load_unsigned, dmem_ack;
    logic [1:0]  mem_size;
    logic        dmem_req, dmem_we, stall, wb_reg_write, exc_misaligned, exc_bus_timeout;
    logic [31:0] dmem_addr, dmem_wdata, wb_result;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .mem_alu_result(mem_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_store_data(mem_store_data), .mem_size(mem_size),
        .mem_load_unsigned(mem_load_unsigned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall),
        .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .exc_misaligned(exc_misaligned), .exc_bus_timeout(exc_bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [1:0]  size;
        logic        uns;
        logic        rd_en;
        logic        wr_en;
        logic [4:0]  rd;
        logic        rw;
        int          ack_at;    // REQ cycle (1-based) carrying ack; 0 = never
        logic [31:0] rdata;
        int          e_stalls;
        logic [31:0] e_result;
        logic        e_rw;
        logic        e_mis;
        logic        e_to;
        logic        e_bus;
        logic        e_we;
        logic [31:0] e_daddr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(
        logic [31:0] addr, logic [31:0] sdata, logic [1:0] size, logic uns,
        logic rd_en, logic wr_en, logic [4:0] rd, logic rw, int ack_at, logic [31:0] rdata,
        int e_stalls, logic [31:0] e_result, logic e_rw, logic e_mis, logic e_to,
        logic e_bus, logic e_we, logic [31:0] e_daddr, logic [3:0] e_be, logic [31:0] e_wdata);
        vec_t v;
        v.addr = addr; v.sdata = sdata; v.size = size; v.uns = uns;
        v.rd_en = rd_en; v.wr_en = wr_en; v.rd = rd; v.rw = rw;
        v.ack_at = ack_at; v.rdata = rdata; v.e_stalls = e_stalls;
        v.e_result = e_result; v.e_rw = e_rw; v.e_mis = e_mis; v.e_to = e_to;
        v.e_bus = e_bus; v.e_we = e_we; v.e_daddr = e_daddr; v.e_be = e_be;
        v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        mem_alu_result = 32'h0; mem_rd = 5'd0; mem_reg_write = 1'b0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_store_data = 32'h0;
        mem_size = 2'b10; mem_load_unsigned = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    // Entered and left just after a rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        int   stalls = 0;
        int   req_cycles = 0;
        bit   done = 0;
        bit   saw_req = 0;
        vec_t e;
        mem_alu_result = v.addr; mem_store_data = v.sdata; mem_size = v.size;
        mem_load_unsigned = v.uns; mem_mem_read = v.rd_en; mem_mem_write = v.wr_en;
        mem_rd = v.rd; mem_reg_write = v.rw; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        sb_q.push_back(v);
        for (int c = 0; c < 40 && !done; c++) begin
            if (dmem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    saw_req = 1;
                    check($sformatf("v%0d dmem_addr", idx), dmem_addr, v.e_daddr);
                    check($sformatf("v%0d dmem_we", idx), 32'(dmem_we), 32'(v.e_we));
                    if (v.e_we) begin
                        check($sformatf("v%0d dmem_be", idx), 32'(dmem_be), 32'(v.e_be));
                        check($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.e_wdata);
                    end
                end
                dmem_ack   = (v.ack_at == req_cycles);
                dmem_rdata = v.rdata;
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk);
            if (stall) stalls++;
            else done = 1;
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL v%0d completion: stall never released within budget", idx);
        end
        e = sb_q.pop_front();
        check($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(e.e_stalls));
        check($sformatf("v%0d bus_used", idx), 32'(saw_req), 32'(e.e_bus));
        check($sformatf("v%0d wb_reg_write", idx), 32'(wb_reg_write), 32'(e.e_rw));
        check($sformatf("v%0d exc_misaligned", idx), 32'(exc_misaligned), 32'(e.e_mis));
        check($sformatf("v%0d exc_bus_timeout", idx), 32'(exc_bus_timeout), 32'(e.e_to));
        if (e.e_rw) begin
            check($sformatf("v%0d wb_result", idx), wb_result, e.e_result);
            check($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(e.rd));
        end
    endtask

    initial begin
        //          addr          sdata          sz    u  r  w  rd  rw ack rdata          stl result        rw mis to bus we daddr         be       wdata
        vecs.push_back(mk(32'h1234, 32'h0,        2'b10,0, 0, 0, 5,  1, 0, 32'h0,          0, 32'h1234,     1, 0, 0, 0, 0, 32'h0,     4'h0,    32'h0));
        vecs.push_back(mk(32'h103,  32'h0,        2'b00,0, 1, 0, 7,  1, 2, 32'h80FF0000,   2, 32'hFFFFFF80, 1, 0, 0, 1, 0, 32'h100,   4'b1000, 32'h0));
        vecs.push_back(mk(32'h102,  32'hABCD,     2'b01,0, 0, 1, 4,  1, 1, 32'h0,          1, 32'h0,        0, 0, 0, 1, 1, 32'h100,   4'b1100, 32'hABCDABCD));
        vecs.push_back(mk(32'h202,  32'h0,        2'b10,0, 1, 0, 6,  1, 0, 32'h0,          0, 32'h0,        0, 1, 0, 0, 0, 32'h0,     4'h0,    32'h0));
        vecs.push_back(mk(32'h300,  32'h0,        2'b10,0, 1, 0, 8,  1, 0, 32'h0,          4, 32'h0,        0, 0, 1, 1, 0, 32'h300,   4'hF,    32'h0));
        vecs.push_back(mk(32'h300,  32'h0,        2'b10,0, 1, 0, 9,  1, 4, 32'hDEADBEEF,   4, 32'hDEADBEEF, 1, 0, 0, 1, 0, 32'h300,   4'hF,    32'h0));
        vecs.push_back(mk(32'h101,  32'h0,        2'b00,1, 1, 0, 10, 1, 1, 32'h123480AA,   1, 32'h80,       1, 0, 0, 1, 0, 32'h100,   4'b0010, 32'h0));
        vecs.push_back(mk(32'h102,  32'h0,        2'b01,0, 1, 0, 11, 1, 1, 32'h9ABC1234,   1, 32'hFFFF9ABC, 1, 0, 0, 1, 0, 32'h100,   4'b1100, 32'h0));
        vecs.push_back(mk(32'h100,  32'h0,        2'b01,1, 1, 0, 12, 1, 3, 32'h9ABC8765,   3, 32'h8765,     1, 0, 0, 1, 0, 32'h100,   4'b0011, 32'h0));
        vecs.push_back(mk(32'h203,  32'h12345678, 2'b00,0, 0, 1, 0,  0, 1, 32'h0,          1, 32'h0,        0, 0, 0, 1, 1, 32'h200,   4'b1000, 32'h78787878));
        vecs.push_back(mk(32'h204,  32'hCAFEF00D, 2'b10,0, 0, 1, 0,  0, 2, 32'h0,          2, 32'h0,        0, 0, 0, 1, 1, 32'h204,   4'hF,    32'hCAFEF00D));
        vecs.push_back(mk(32'h101,  32'h0,        2'b01,0, 1, 0, 13, 1, 0, 32'h0,          0, 32'h0,        0, 1, 0, 0, 0, 32'h0,     4'h0,    32'h0));
        vecs.push_back(mk(32'h400,  32'h11111111, 2'b10,0, 1, 1, 14, 1, 1, 32'h55AA55AA,   1, 32'h55AA55AA, 1, 0, 0, 1, 0, 32'h400,   4'hF,    32'h0));
        vecs.push_back(mk(32'h404,  32'h0,        2'b11,0, 1, 0, 15, 1, 1, 32'h01020304,   1, 32'h01020304, 1, 0, 0, 1, 0, 32'h404,   4'hF,    32'h0));
        vecs.push_back(mk(32'h001,  32'h0,        2'b00,0, 1, 0, 16, 1, 1, 32'h00007F00,   1, 32'h7F,       1, 0, 0, 1, 0, 32'h0,     4'b0010, 32'h0));
        vecs.push_back(mk(32'hFFFF, 32'h0,        2'b10,0, 0, 0, 0,  1, 0, 32'h0,          0, 32'hFFFF,     1, 0, 0, 0, 0, 32'h0,     4'h0,    32'h0));
        vecs.push_back(mk(32'h206,  32'h1,        2'b10,0, 0, 1, 0,  0, 0, 32'h0,          0, 32'h0,        0, 1, 0, 0, 0, 32'h0,     4'h0,    32'h0));

        // Reset state (an aligned load is presented to show stall is held low)
        drive_nop();
        reset = 1'b1;
        mem_mem_read = 1'b1;
        #2;
        check("reset dmem_req", 32'(dmem_req), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        check("reset wb_reg_write", 32'(wb_reg_write), 32'h0);
        check("reset wb_result", wb_result, 32'h0);
        check("reset exc", 32'({exc_misaligned, exc_bus_timeout}), 32'h0);
        check("reset dmem_addr", dmem_addr, 32'h0);
        drive_nop();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Exception outputs are single-cycle pulses
        run_vec(100, vecs[3]);
        drive_nop();
        @(posedge clk); #1;
        check("misaligned pulse width", 32'(exc_misaligned), 32'h0);
        run_vec(101, vecs[4]);
        drive_nop();
        @(negedge clk);
        check("post-timeout stall", 32'(stall), 32'h0);
        check("post-timeout dmem_req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        check("timeout pulse width", 32'(exc_bus_timeout), 32'h0);

        // dmem_ack is ignored in IDLE
        drive_nop();
        mem_alu_result = 32'h77; mem_rd = 5'd2; mem_reg_write = 1'b1; dmem_ack = 1'b1;
        @(negedge clk);
        check("idle ack stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        check("idle ack dmem_req", 32'(dmem_req), 32'h0);
        check("idle ack wb_result", wb_result, 32'h77);
        drive_nop();

        // Reset while in REQ drops the request at once
        mem_alu_result = 32'h500; mem_rd = 5'd3; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        @(posedge clk); #1;
        check("pre-reset dmem_req", 32'(dmem_req), 32'h1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("mid-reset dmem_req", 32'(dmem_req), 32'h0);
        check("mid-reset stall", 32'(stall), 32'h0);
        drive_nop();
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec(102, vecs[5]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
